stream_burst_arbiter: RTL
=========================

# stream_burst_arbiter

Round-robin arbiter sharing one valid/ready stream channel between `NumInp` requesters, with per-burst grant locking so beats of different bursts never interleave. It sits in front of a shared datapath port (e.g. a backend write channel) and drives it through a single full-throughput output register stage. Every beat leaving it carries the index of the requester that sourced it.

## Interface
- `NumInp`, default 4: number of requesters; legal range 1..32.
- `DataWidth`, default 32: payload width in bits.
- `IdxWidth`, default `NumInp > 1 ? $clog2(NumInp) : 1`: width of the requester index; derived, never overridden.
- `clk_i`  in  1  clock; all logic on the rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `inp_valid_i`  in  NumInp  per-requester beat valid.
- `inp_ready_o`  out  NumInp  per-requester beat ready; at most one bit set per cycle.
- `inp_data_i`  in  NumInp x DataWidth  per-requester payload.
- `inp_last_i`  in  NumInp  per-requester last-beat-of-burst flag.
- `oup_valid_o`  out  1  output beat valid (registered).
- `oup_ready_i`  in  1  downstream ready.
- `oup_data_o`  out  DataWidth  output payload (registered).
- `oup_last_o`  out  1  output last flag (registered).
- `oup_idx_o`  out  IdxWidth  index of the sourcing requester (registered).
- `busy_o`  out  1  high while a burst is locked (state LOCKED).

## Operation
- State machine, two states:
  - IDLE: no burst open.
  - LOCKED: burst open on `lock_idx`.
- `accept = !oup_valid_o || oup_ready_i`. The output register loads only when `accept` is high.
- In IDLE:
  - The grant goes to the first `i` with `inp_valid_i[i]`, searching from `rr_ptr` upward and wrapping N-1 -> 0.
  - `inp_ready_o[grant] = accept`. All other ready bits are low.
  - A handshake with `inp_last_i = 1` stays in IDLE and sets `rr_ptr = (grant+1) mod NumInp`.
  - A handshake with `inp_last_i = 0` moves to LOCKED with `lock_idx = grant`.
- In LOCKED:
  - `inp_ready_o[lock_idx] = accept`. All other ready bits are low, whatever their valids are.
  - A handshake with `inp_last_i = 1` returns to IDLE and sets `rr_ptr = (lock_idx+1) mod NumInp`.
- On any input handshake the register captures data, last and index, and `oup_valid_o` is set.
- When `oup_ready_i` is high and no new beat is loaded, `oup_valid_o` clears.
- `NumInp = 1`: `rr_ptr` and `oup_idx_o` are constant 0. Locking still applies but has no visible effect.
- `inp_ready_o` may depend combinationally on `inp_valid_i` in IDLE (grant selection). It never depends on `inp_data_i`.
- Requesters must hold valid, data and last stable until their handshake. Behaviour is undefined if they do not.
- Reset values: `oup_valid_o = 0`, `oup_data_o = 0`, `oup_last_o = 0`, `oup_idx_o = 0`, `busy_o = 0`, `rr_ptr = 0`, state IDLE.

## Timing
- Latency: an input handshake in cycle t gives `oup_valid_o` high in cycle t+1.
- Throughput: one beat per cycle when `oup_ready_i` is held high.
- `oup_*` stay stable while `oup_valid_o && !oup_ready_i`. In that condition all `inp_ready_o` bits are 0.
- A burst ending in cycle t (last handshake) lets a different requester be granted in cycle t+1. There is no idle bubble.
- The new `rr_ptr` takes effect in the cycle after the last handshake. It does not update on a stall.
- Reset asserted mid-burst:
  - the lock is released and the register is emptied next cycle;
  - the partially sent burst is dropped without a synthetic last;
  - all ready bits are low during reset.
- `busy_o` goes high the cycle after the first non-last handshake. It goes low the cycle after the last handshake.

## Test plan
- Round-robin, single-beat bursts, NumInp=4:
  - Stimulus: all four valids held with last=1, `oup_ready_i = 1`.
  - Required: `oup_idx_o` sequence 0,1,2,3,0,…, one beat per cycle; `oup_data_o` matches each source.
- Burst lock:
  - Stimulus: req1 sends a 3-beat burst (last on beat 3) while req0, req2 and req3 hold valid.
  - Required: three consecutive idx=1 beats, then idx=2 next; `busy_o` high for exactly 2 cycles.
- Backpressure:
  - Stimulus: `oup_ready_i = 0` for 5 cycles during a burst.
  - Required: outputs frozen, all `inp_ready_o = 0`, no beat lost or duplicated after release.
- Wrap-around:
  - Stimulus: only req3 valid, single beat, then only req0 and req2 valid.
  - Required: order 3, 0, 2; `rr_ptr` wraps to 0 after req3.
- Reset mid-burst:
  - Stimulus: assert `rst_i` after beat 2 of a 4-beat burst from req2.
  - Required: next cycle `oup_valid_o = 0`, `busy_o = 0`; after release, req0 is granted first when all are valid.
- NumInp=1:
  - Stimulus: continuous stream.
  - Required: pass-through with 1-cycle latency, `oup_idx_o = 0`, full throughput.

Source files
------------

// File: rtl/stream_burst_arbiter.sv
// Round-robin arbiter for one valid/ready stream shared by NumInp requesters.
// A burst that starts with a non-last beat locks the grant to its requester
// until its last beat, so bursts never interleave. A single full-throughput
// register stage drives the output channel and tags each beat with its source.
module stream_burst_arbiter #(
    parameter int unsigned NumInp    = 4,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned IdxWidth  = (NumInp > 1) ? $clog2(NumInp) : 1
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NumInp-1:0]                inp_valid_i,
    output logic [NumInp-1:0]                inp_ready_o,
    input  logic [NumInp-1:0][DataWidth-1:0] inp_data_i,
    input  logic [NumInp-1:0]                inp_last_i,
    output logic                             oup_valid_o,
    input  logic                             oup_ready_i,
    output logic [DataWidth-1:0]             oup_data_o,
    output logic                             oup_last_o,
    output logic [IdxWidth-1:0]              oup_idx_o,
    output logic                             busy_o
);

    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    state_e                 state_q;
    logic [IdxWidth-1:0]    lock_idx_q;
    logic [IdxWidth-1:0]    rr_ptr_q;
    logic                   oup_valid_q;
    logic [DataWidth-1:0]   oup_data_q;
    logic                   oup_last_q;
    logic [IdxWidth-1:0]    oup_idx_q;
    logic                   busy_q;

    logic                   accept;
    logic                   found_hi, found_lo, grant_found;
    logic [IdxWidth-1:0]    hi_idx, lo_idx, grant_idx;
    logic                   sel_en;
    logic [IdxWidth-1:0]    sel_idx;
    logic                   sel_valid;
    logic [DataWidth-1:0]   sel_data;
    logic                   sel_last;
    logic                   hs;
    logic [IdxWidth-1:0]    rr_ptr_d;

    // Round-robin grant search: lowest valid index at or above rr_ptr wins,
    // otherwise the lowest valid index below it (wrap-around).
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        // Downward scan so the lowest qualifying index is the final assignment.
        for (int i = NumInp - 1; i >= 0; i--) begin
            if (inp_valid_i[i]) begin
                if (IdxWidth'(i) >= rr_ptr_q) begin
                    hi_idx   = IdxWidth'(i);
                    found_hi = 1'b1;
                end else begin
                    lo_idx   = IdxWidth'(i);
                    found_lo = 1'b1;
                end
            end
        end
        grant_found = found_hi || found_lo;
        grant_idx   = found_hi ? hi_idx : lo_idx;
    end

    // Select the active requester, drive its ready and detect the input handshake.
    always_comb begin
        accept      = !oup_valid_q || oup_ready_i;
        sel_en      = (state_q == StLocked) || grant_found;
        sel_idx     = (state_q == StLocked) ? lock_idx_q : grant_idx;
        sel_valid   = 1'b0;
        sel_data    = '0;
        sel_last    = 1'b0;
        inp_ready_o = '0;
        for (int i = 0; i < NumInp; i++) begin
            if (IdxWidth'(i) == sel_idx) begin
                sel_valid      = inp_valid_i[i];
                sel_data       = inp_data_i[i];
                sel_last       = inp_last_i[i];
                inp_ready_o[i] = sel_en && accept && !rst_i;
            end
        end
        hs       = sel_en && accept && sel_valid && !rst_i;
        rr_ptr_d = (sel_idx == IdxWidth'(NumInp - 1)) ? '0 : sel_idx + IdxWidth'(1);
    end

    // Burst-lock FSM together with the output register stage.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            lock_idx_q  <= '0;
            rr_ptr_q    <= '0;
            oup_valid_q <= 1'b0;
            oup_data_q  <= '0;
            oup_last_q  <= 1'b0;
            oup_idx_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            if (hs) begin
                oup_valid_q <= 1'b1;
                oup_data_q  <= sel_data;
                oup_last_q  <= sel_last;
                oup_idx_q   <= sel_idx;
                if (sel_last) begin
                    state_q  <= StIdle;
                    busy_q   <= 1'b0;
                    rr_ptr_q <= rr_ptr_d;
                end else begin
                    state_q    <= StLocked;
                    busy_q     <= 1'b1;
                    lock_idx_q <= sel_idx;
                end
            end else if (oup_ready_i) begin
                oup_valid_q <= 1'b0;
            end
        end
    end

    assign oup_valid_o = oup_valid_q;
    assign oup_data_o  = oup_data_q;
    assign oup_last_o  = oup_last_q;
    assign oup_idx_o   = oup_idx_q;
    assign busy_o      = busy_q;

endmodule
